// File: rtl/sub_sched_pkg.sv
// ---------------------------------------------------------------------------
// sub_sched_pkg
// Shared types and helpers for the round-robin subtractor scheduler.
//   sched_state_t   : scheduler FSM states
//   DEF_*           : default parameter values used by the scheduler top
//   sched_cnt_w()   : width of the S_WAIT timeout counter, $clog2(TIMEOUT+1)
// ---------------------------------------------------------------------------
package sub_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_ABORT = 3'd4
    } sched_state_t;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_W       = 8;
    localparam int DEF_TIMEOUT = 15;

    // Counter must be able to hold the value TIMEOUT itself.
    function automatic int sched_cnt_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    localparam int DEF_CNT_W = sched_cnt_w(DEF_TIMEOUT);

endpackage

// File: rtl/sub_rr_scheduler_rr_pick.sv
// ---------------------------------------------------------------------------
// sub_rr_scheduler_rr_pick
// Combinational round-robin picker. Searches i_ptr+1, i_ptr+2, ... modulo
// N_REQ and returns the first requester with its request bit set.
//   i_req    [N_REQ-1:0]  request vector
//   i_ptr    [PTR_W-1:0]  last served requester (lowest priority)
//   o_winner [PTR_W-1:0]  index of the winning requester
//   o_valid               at least one request is present
// ---------------------------------------------------------------------------
module sub_rr_scheduler_rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [PTR_W-1:0] o_winner,
    output logic             o_valid
);

    // One extra bit so ptr + offset (at most 2*N_REQ-1) never overflows.
    localparam int              CW  = PTR_W + 1;
    localparam logic [CW-1:0]   N_C = CW'(N_REQ);

    logic [CW-1:0] w_cand;
    logic [CW-1:0] w_idx;

    // Walk from the farthest offset to the nearest one so that the nearest
    // requesting candidate is the last (and therefore final) assignment.
    always_comb begin
        o_winner = '0;
        o_valid  = 1'b0;
        w_cand   = '0;
        w_idx    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_cand = {1'b0, i_ptr} + CW'(k + 1);
            w_idx  = (w_cand >= N_C) ? (w_cand - N_C) : w_cand;
            if (i_req[w_idx[PTR_W-1:0]]) begin
                o_winner = w_idx[PTR_W-1:0];
                o_valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sub_rr_scheduler.sv
// ---------------------------------------------------------------------------
// sub_rr_scheduler
// Shares one multi-cycle subtractor (start/rdy/result handshake) among N_REQ
// requesters with round-robin arbitration and a completion timeout.
//   clk, rst_b          clock, asynchronous active-low reset
//   req   [N_REQ]       level requests, held until grant
//   a_in, b_in          packed operands, requester i at [i*W +: W]
//   grant [N_REQ]       one-hot pulse: operands of that requester accepted
//   done  [N_REQ]       one-hot pulse: result_out valid for that requester
//   err   [N_REQ]       one-hot pulse: shared unit timed out for that requester
//   result_out [W]      last captured result, held until next capture
//   busy                scheduler not idle
//   sub_start, sub_a, sub_b, sub_rdy, sub_result   shared-unit interface
// All outputs come from registers or from a decode of the state/owner
// registers, so nothing on req or sub_rdy reaches an output combinationally.
// ---------------------------------------------------------------------------
module sub_rr_scheduler
    import sub_sched_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int W       = DEF_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] a_in,
    input  logic [N_REQ*W-1:0] b_in,
    output logic [N_REQ-1:0]   grant,
    output logic [N_REQ-1:0]   done,
    output logic [N_REQ-1:0]   err,
    output logic [W-1:0]       result_out,
    output logic               busy,
    output logic               sub_start,
    output logic [W-1:0]       sub_a,
    output logic [W-1:0]       sub_b,
    input  logic               sub_rdy,
    input  logic [W-1:0]       sub_result
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = sched_cnt_w(TIMEOUT);

    sched_state_t     r_state, w_state_next;
    logic [PTR_W-1:0] r_owner, w_owner_next;
    logic [PTR_W-1:0] r_ptr,   w_ptr_next;
    logic [CNT_W-1:0] r_cnt,   w_cnt_next;
    logic [W-1:0]     r_sub_a, w_sub_a_next;
    logic [W-1:0]     r_sub_b, w_sub_b_next;
    logic [W-1:0]     r_result, w_result_next;

    logic [PTR_W-1:0] w_winner;
    logic             w_valid;
    logic [W-1:0]     w_a_arr [N_REQ];
    logic [W-1:0]     w_b_arr [N_REQ];

    sub_rr_scheduler_rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_winner (w_winner),
        .o_valid  (w_valid)
    );

    // Unpack operands and decode the one-hot strobes from state + owner.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            assign w_a_arr[gi] = a_in[gi*W +: W];
            assign w_b_arr[gi] = b_in[gi*W +: W];
            assign grant[gi]   = (r_state == S_ISSUE) && (r_owner == PTR_W'(gi));
            assign done[gi]    = (r_state == S_DONE)  && (r_owner == PTR_W'(gi));
            assign err[gi]     = (r_state == S_ABORT) && (r_owner == PTR_W'(gi));
        end
    endgenerate

    assign busy       = (r_state != S_IDLE);
    assign sub_start  = (r_state == S_ISSUE);
    assign sub_a      = r_sub_a;
    assign sub_b      = r_sub_b;
    assign result_out = r_result;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state  <= S_IDLE;
            r_owner  <= '0;
            // Last-served pointer at the top index so requester 0 wins first.
            r_ptr    <= PTR_W'(N_REQ - 1);
            r_cnt    <= '0;
            r_sub_a  <= '0;
            r_sub_b  <= '0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_next;
            r_owner  <= w_owner_next;
            r_ptr    <= w_ptr_next;
            r_cnt    <= w_cnt_next;
            r_sub_a  <= w_sub_a_next;
            r_sub_b  <= w_sub_b_next;
            r_result <= w_result_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_owner_next  = r_owner;
        w_ptr_next    = r_ptr;
        w_cnt_next    = r_cnt;
        w_sub_a_next  = r_sub_a;
        w_sub_b_next  = r_sub_b;
        w_result_next = r_result;
        case (r_state)
            S_IDLE: begin
                // Only arbitrate when the shared unit can take a new job.
                if (w_valid && sub_rdy) begin
                    w_owner_next = w_winner;
                    w_sub_a_next = w_a_arr[w_winner];
                    w_sub_b_next = w_b_arr[w_winner];
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_cnt_next   = '0;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                // The unit drops rdy the cycle after start, so rdy seen here
                // always belongs to the job just issued.
                if (sub_rdy) begin
                    w_result_next = sub_result;
                    w_state_next  = S_DONE;
                end else if (r_cnt == CNT_W'(TIMEOUT)) begin
                    w_state_next = S_ABORT;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_DONE: begin
                w_ptr_next   = r_owner;
                w_state_next = S_IDLE;
            end
            S_ABORT: begin
                w_ptr_next   = r_owner;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule
